// File: rtl/serout_fifoarb_pkg.sv
// serout_pkg: shared definitions for the serial-output FIFO controller / arbiter.
//   LB2BUFSZ_DEF  log2 of per-port FIFO depth in bytes
//   LOGNPORT_DEF  log2 of number of transmit ports
//   NPORT_DEF     number of transmit ports
//   PTR_W         width of each per-port read/write pointer
//   state_e       read-port grant sequencer states
package serout_pkg;

  localparam int LB2BUFSZ_DEF = 5;
  localparam int LOGNPORT_DEF = 3;
  localparam int NPORT_DEF    = 1 << LOGNPORT_DEF;
  localparam int PTR_W        = LB2BUFSZ_DEF;

  typedef enum logic [1:0] {
    IDLE,  // looking for an eligible requester
    ADDR,  // RAM samples ram_ra
    DATA   // ram_rd valid, byte is popped
  } state_e;

endpackage

// File: rtl/serout_fifoarb_if.sv
// serout_fifoarb_if: host-write, transmitter request/grant and RAM-port bundle.
//   slave  modport: the FIFO controller (serout_fifoarb)
//   master modport: host decode / transmitters / RAM wrapper
// Optional macro SEROUT_FIFOARB_FLUSH_EN adds the per-port flush vector.
interface serout_fifoarb_if #(
  parameter int NPORT    = serout_pkg::NPORT_DEF,
  parameter int LOGNPORT = serout_pkg::LOGNPORT_DEF,
  parameter int LB2BUFSZ = serout_pkg::PTR_W
);

  localparam int AW = LOGNPORT + LB2BUFSZ;

`ifdef SEROUT_FIFOARB_FLUSH_EN
  logic [NPORT-1:0]    flush;
`endif
  logic                wr_en;
  logic [LOGNPORT-1:0] wr_port;
  logic [7:0]          wr_data;
  logic                wr_accept;
  logic [NPORT-1:0]    req;
  logic                gnt_valid;
  logic [LOGNPORT-1:0] gnt_port;
  logic [7:0]          gnt_data;
  logic [NPORT-1:0]    full;
  logic [NPORT-1:0]    empty;
  logic                ram_we;
  logic [AW-1:0]       ram_wa;
  logic [7:0]          ram_wd;
  logic [AW-1:0]       ram_ra;
  logic [7:0]          ram_rd;

  modport slave (
`ifdef SEROUT_FIFOARB_FLUSH_EN
    input  flush,
`endif
    input  wr_en, wr_port, wr_data, req, ram_rd,
    output wr_accept, gnt_valid, gnt_port, gnt_data, full, empty,
    output ram_we, ram_wa, ram_wd, ram_ra
  );

  modport master (
`ifdef SEROUT_FIFOARB_FLUSH_EN
    output flush,
`endif
    output wr_en, wr_port, wr_data, req, ram_rd,
    input  wr_accept, gnt_valid, gnt_port, gnt_data, full, empty,
    input  ram_we, ram_wa, ram_wd, ram_ra
  );

endinterface

// File: rtl/serout_fifoarb_rr_pick.sv
// rr_pick: combinational round-robin picker.
//   elig     in  NPORT     eligible requesters
//   rr_last  in  LOGNPORT  most recently granted port
//   any      out 1         at least one eligible requester
//   sel      out LOGNPORT  first eligible port scanning upward from rr_last+1
module rr_pick #(
  parameter int NPORT    = 8,
  parameter int LOGNPORT = 3
) (
  input  logic [NPORT-1:0]    elig,
  input  logic [LOGNPORT-1:0] rr_last,
  output logic                any,
  output logic [LOGNPORT-1:0] sel
);

  logic [LOGNPORT-1:0] idx;

  // Scan from the farthest offset down to rr_last+1 so the closest
  // eligible port is the last one written and therefore wins.
  always_comb begin
    any = |elig;
    sel = rr_last;
    idx = rr_last;
    for (int off = NPORT; off >= 1; off--) begin
      idx = LOGNPORT'((int'(rr_last) + off) % NPORT);
      if (elig[idx]) sel = idx;
    end
  end

endmodule

// File: rtl/serout_fifoarb.sv
// serout_fifoarb: per-port FIFO pointers over a shared dual-port byte RAM,
// host write acceptance, and round-robin arbitration of the RAM read port.
//   clk, reset_n       clock, asynchronous active-low reset
//   bus (slave)        host write, request/grant, full/empty, RAM ports
// One grant takes IDLE -> ADDR -> DATA; gnt_valid pulses in the cycle after
// DATA, overlapping the next IDLE.
// Optional macro SEROUT_FIFOARB_FLUSH_EN: per-port flush that discards the
// FIFO contents and cancels an in-flight grant for that port.
module serout_fifoarb
  import serout_pkg::*;
#(
  parameter int NPORT    = NPORT_DEF,
  parameter int LOGNPORT = LOGNPORT_DEF,
  parameter int LB2BUFSZ = PTR_W
) (
  input  logic            clk,
  input  logic            reset_n,
  serout_fifoarb_if.slave bus
);

  localparam int AW = LOGNPORT + LB2BUFSZ;
  typedef logic [LB2BUFSZ-1:0] ptr_t;

  state_e              state_q, state_d;
  ptr_t                watx_q [NPORT];
  ptr_t                watx_d [NPORT];
  ptr_t                ratx_q [NPORT];
  ptr_t                ratx_d [NPORT];
  logic [LOGNPORT-1:0] sel_q, sel_d, rr_last_q, rr_last_d;
  logic [LOGNPORT-1:0] gnt_port_q, gnt_port_d;
  logic [AW-1:0]       ram_ra_q, ram_ra_d;
  logic                gnt_valid_q, gnt_valid_d;
  logic [7:0]          gnt_data_q, gnt_data_d;

  logic [NPORT-1:0]    full, empty, elig, gnt_mask;
  logic                wr_accept, pop, pick_any;
  logic [LOGNPORT-1:0] pick_sel;

  // Pointer comparisons; full wraps the incremented write pointer.
  always_comb begin
    full  = '0;
    empty = '0;
    for (int i = 0; i < NPORT; i++) begin
      empty[i] = (watx_q[i] == ratx_q[i]);
      full[i]  = (ptr_t'(watx_q[i] + 1'b1) == ratx_q[i]);
    end
  end

  assign wr_accept     = bus.wr_en & ~full[bus.wr_port];
  assign bus.wr_accept = wr_accept;
  assign bus.ram_we    = wr_accept;
  assign bus.ram_wa    = {bus.wr_port, watx_q[bus.wr_port]};
  assign bus.ram_wd    = bus.wr_data;
  assign bus.ram_ra    = ram_ra_q;
  assign bus.gnt_valid = gnt_valid_q;
  assign bus.gnt_port  = gnt_port_q;
  assign bus.gnt_data  = gnt_data_q;
  assign bus.full      = full;
  assign bus.empty     = empty;

  // The port just served has its pointer already bumped, but may still hold
  // req this cycle; keep it out so it is not granted twice back to back.
  always_comb begin
    gnt_mask = '0;
    if (gnt_valid_q) gnt_mask[gnt_port_q] = 1'b1;
  end

`ifdef SEROUT_FIFOARB_FLUSH_EN
  logic cancel_q, cancel_d;

  // A port being flushed is never picked: its read pointer is about to jump.
  assign elig = bus.req & ~empty & ~gnt_mask & ~bus.flush;
  assign pop  = (state_q == DATA) & ~cancel_q & ~bus.flush[sel_q];
`else
  assign elig = bus.req & ~empty & ~gnt_mask;
  assign pop  = (state_q == DATA);
`endif

  rr_pick #(
    .NPORT    (NPORT),
    .LOGNPORT (LOGNPORT)
  ) u_rr_pick (
    .elig    (elig),
    .rr_last (rr_last_q),
    .any     (pick_any),
    .sel     (pick_sel)
  );

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: non-blocking assignments in clocked blocks so every flop samples
    // pre-edge values regardless of block ordering.
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default assignment first so no path leaves state_d unassigned,
    // which would infer a latch.
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (pick_any) state_d = ADDR;
      ADDR:    state_d = DATA;
      DATA:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output / datapath logic.
  always_comb begin
    watx_d      = watx_q;
    ratx_d      = ratx_q;
    sel_d       = sel_q;
    rr_last_d   = rr_last_q;
    ram_ra_d    = ram_ra_q;
    gnt_valid_d = 1'b0;
    gnt_port_d  = gnt_port_q;
    gnt_data_d  = gnt_data_q;
`ifdef SEROUT_FIFOARB_FLUSH_EN
    cancel_d    = cancel_q;
`endif

    if (wr_accept) watx_d[bus.wr_port] = watx_q[bus.wr_port] + 1'b1;

    if ((state_q == IDLE) && pick_any) begin
      sel_d     = pick_sel;
      rr_last_d = pick_sel;
      ram_ra_d  = {pick_sel, ratx_q[pick_sel]};
`ifdef SEROUT_FIFOARB_FLUSH_EN
      cancel_d  = 1'b0;
`endif
    end

`ifdef SEROUT_FIFOARB_FLUSH_EN
    if ((state_q == ADDR) && bus.flush[sel_q]) cancel_d = 1'b1;
`endif

    if (pop) begin
      gnt_valid_d    = 1'b1;
      gnt_port_d     = sel_q;
      gnt_data_d     = bus.ram_rd;
      ratx_d[sel_q]  = ratx_q[sel_q] + 1'b1;
    end

`ifdef SEROUT_FIFOARB_FLUSH_EN
    // Flush follows the post-write pointer so a same-cycle write is dropped too.
    for (int i = 0; i < NPORT; i++) begin
      if (bus.flush[i]) ratx_d[i] = watx_d[i];
    end
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: the pointer arrays are ordinary flops and must be reset to give
      // empty FIFOs; the byte RAM they index is external and needs no reset.
      for (int i = 0; i < NPORT; i++) begin
        watx_q[i] <= '0;
        ratx_q[i] <= '0;
      end
      sel_q       <= '0;
      rr_last_q   <= LOGNPORT'(NPORT - 1);
      ram_ra_q    <= '0;
      gnt_valid_q <= 1'b0;
      gnt_port_q  <= '0;
      gnt_data_q  <= '0;
`ifdef SEROUT_FIFOARB_FLUSH_EN
      cancel_q    <= 1'b0;
`endif
    end else begin
      watx_q      <= watx_d;
      ratx_q      <= ratx_d;
      sel_q       <= sel_d;
      rr_last_q   <= rr_last_d;
      ram_ra_q    <= ram_ra_d;
      gnt_valid_q <= gnt_valid_d;
      gnt_port_q  <= gnt_port_d;
      gnt_data_q  <= gnt_data_d;
`ifdef SEROUT_FIFOARB_FLUSH_EN
      cancel_q    <= cancel_d;
`endif
    end
  end

endmodule

// File: tb/tb_serout_fifoarb.sv
// tb_serout_fifoarb: directed bench for serout_fifoarb with a registered-read
// byte RAM model. Inputs change just after the falling edge; outputs are
// sampled there (plus #1 where combinational outputs follow new inputs).
module tb_serout_fifoarb;
  import serout_pkg::*;

  logic clk;
  logic reset_n;

  serout_fifoarb_if bus ();

  serout_fifoarb dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Dual-port byte RAM, one-cycle registered read.
  logic [7:0] mem [256];
  always @(posedge clk) begin
    if (bus.ram_we) mem[bus.ram_wa] <= bus.ram_wd;
    bus.ram_rd <= mem[bus.ram_ra];
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic write_byte(input logic [2:0] p, input logic [7:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_port = p;
    bus.wr_data = d;
    tick();
    bus.wr_en   = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int acc, got, n, last;
    int ports [3];
    logic [2:0] exp_p [6];
    logic [7:0] exp_d [6];

    ports = '{0, 3, 7};
    exp_p = '{3'd0, 3'd3, 3'd7, 3'd0, 3'd3, 3'd7};
    exp_d = '{8'h00, 8'h30, 8'h70, 8'h01, 8'h31, 8'h71};

    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    reset_n     = 1'b0;
    bus.wr_en   = 1'b0;
    bus.wr_port = '0;
    bus.wr_data = '0;
    bus.req     = '0;
`ifdef SEROUT_FIFOARB_FLUSH_EN
    bus.flush   = '0;
`endif
    repeat (3) tick();
    reset_n = 1'b1;
    tick();

    // Reset state.
    check("rst_gnt_valid", bus.gnt_valid, 0);
    check("rst_gnt_port",  bus.gnt_port, 0);
    check("rst_gnt_data",  bus.gnt_data, 0);
    check("rst_ram_ra",    bus.ram_ra, 0);
    check("rst_empty",     bus.empty, 8'hFF);
    check("rst_full",      bus.full, 8'h00);

    // Single byte to port 2, grant 3 cycles after the request is sampled.
    bus.wr_en = 1'b1; bus.wr_port = 3'd2; bus.wr_data = 8'h55;
    #1;
    check("t1_wr_accept", bus.wr_accept, 1);
    check("t1_ram_wa",    bus.ram_wa, 8'h40);
    tick();
    bus.wr_en = 1'b0;
    bus.req   = 8'h04;
    check("t1_not_empty", bus.empty[2], 0);
    tick();
    check("t1_no_gnt_k1", bus.gnt_valid, 0);
    tick();
    check("t1_no_gnt_k2", bus.gnt_valid, 0);
    tick();
    check("t1_gnt_valid", bus.gnt_valid, 1);
    check("t1_gnt_port",  bus.gnt_port, 2);
    check("t1_gnt_data",  bus.gnt_data, 8'h55);
    check("t1_empty_after", bus.empty[2], 1);
    bus.req = '0;
    tick();

    // Fill port 0: 31 accepted, 32nd rejected; drain in order.
    acc = 0;
    for (int i = 0; i < 32; i++) begin
      bus.wr_en = 1'b1; bus.wr_port = 3'd0; bus.wr_data = 8'(i);
      #1;
      if (bus.wr_accept) acc++;
      if (i == 31) begin
        check("t2_reject",  bus.wr_accept, 0);
        check("t2_ram_we",  bus.ram_we, 0);
        check("t2_full",    bus.full[0], 1);
      end
      tick();
    end
    bus.wr_en = 1'b0;
    check("t2_accepted", acc, 31);
    bus.req = 8'h01;
    got = 0;
    for (int c = 0; c < 200 && got < 31; c++) begin
      tick();
      if (bus.gnt_valid) begin
        check("t2_drain_data", bus.gnt_data, got);
        check("t2_drain_port", bus.gnt_port, 0);
        got++;
      end
    end
    check("t2_drain_count", got, 31);
    check("t2_drain_empty", bus.empty[0], 1);
    bus.req = '0;

    // Round robin across ports 0, 3, 7 from a fresh reset.
    do_reset();
    for (int j = 0; j < 2; j++)
      foreach (ports[k]) write_byte(3'(ports[k]), 8'(ports[k] * 16 + j));
    bus.req = 8'h89;
    got  = 0;
    last = 0;
    for (int c = 0; c < 100 && got < 6; c++) begin
      tick();
      if (bus.gnt_valid) begin
        check("t3_port", bus.gnt_port, exp_p[got]);
        check("t3_data", bus.gnt_data, exp_d[got]);
        if (got > 0) check("t3_spacing", c - last, 3);
        last = c;
        got++;
      end
    end
    check("t3_count", got, 6);
    check("t3_all_empty", bus.empty, 8'hFF);
    bus.req = '0;
    tick();

    // Pending request on empty port 4: no grant until data arrives.
    bus.req = 8'h10;
    n = 0;
    repeat (20) begin
      tick();
      if (bus.gnt_valid) n++;
    end
    check("t4_no_gnt", n, 0);
    check("t4_ram_ra_hold", bus.ram_ra, 8'hE1);
    write_byte(3'd4, 8'h44);
    n = 0;
    if (bus.gnt_valid) n++;
    tick();
    if (bus.gnt_valid) n++;
    tick();
    if (bus.gnt_valid) n++;
    check("t4_no_early_gnt", n, 0);
    tick();
    check("t4_gnt_valid", bus.gnt_valid, 1);
    check("t4_gnt_port",  bus.gnt_port, 4);
    check("t4_gnt_data",  bus.gnt_data, 8'h44);
    bus.req = '0;
    tick();

    // Write to port 1 in the same cycle as its DATA-state pop.
    write_byte(3'd1, 8'hA1);
    bus.req = 8'h02;
    tick();
    tick();
    bus.wr_en = 1'b1; bus.wr_port = 3'd1; bus.wr_data = 8'hB2;
    #1;
    check("t5_wr_accept", bus.wr_accept, 1);
    tick();
    bus.wr_en = 1'b0;
    #1;
    check("t5_gnt_valid", bus.gnt_valid, 1);
    check("t5_gnt_data",  bus.gnt_data, 8'hA1);
    check("t5_not_empty", bus.empty[1], 0);
    check("t5_watx",      bus.ram_wa, 8'h22);
    repeat (4) tick();
    check("t5_gnt2_valid", bus.gnt_valid, 1);
    check("t5_gnt2_data",  bus.gnt_data, 8'hB2);
    check("t5_empty_after", bus.empty[1], 1);
    bus.req = '0;
    tick();

    // Reset during ADDR aborts the grant.
    write_byte(3'd5, 8'h66);
    bus.req = 8'h20;
    tick();
    check("t6_ram_ra_addr", bus.ram_ra, 8'hA0);
    reset_n = 1'b0;
    #1;
    check("t6_gnt_valid", bus.gnt_valid, 0);
    check("t6_gnt_port",  bus.gnt_port, 0);
    check("t6_gnt_data",  bus.gnt_data, 0);
    check("t6_ram_ra",    bus.ram_ra, 0);
    check("t6_empty",     bus.empty, 8'hFF);
    check("t6_full",      bus.full, 8'h00);
    n = 0;
    repeat (3) begin
      tick();
      if (bus.gnt_valid) n++;
    end
    reset_n = 1'b1;
    repeat (5) begin
      tick();
      if (bus.gnt_valid) n++;
    end
    check("t6_no_gnt", n, 0);
    check("t6_still_empty", bus.empty, 8'hFF);
    bus.req = '0;
    tick();

`ifdef SEROUT_FIFOARB_FLUSH_EN
    // Flush of the selected port during ADDR cancels the grant.
    write_byte(3'd2, 8'h77);
    bus.req = 8'h04;
    tick();
    bus.flush = 8'h04;
    tick();
    bus.flush = '0;
    n = 0;
    repeat (4) begin
      tick();
      if (bus.gnt_valid) n++;
    end
    check("t7_flush_no_gnt", n, 0);
    check("t7_flush_empty", bus.empty[2], 1);
    bus.req = '0;
    tick();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serout_fifoarb.md
# serout_fifoarb

FIFO controller and read-port arbiter for the multi-port serial output buffer. It owns the per-port write and read pointers of the shared dual-port byte RAM and accepts host writes. It grants the single RAM read port round-robin to NPORT transmitters, delivering one byte per grant. It sits between the host bus decode and the per-port bit shifters, and replaces ad-hoc sequential polling with explicit request/grant.

## Interface
- NPORT, 8: number of transmit ports.
- LOGNPORT, 3: log2(NPORT).
- LB2BUFSZ, 5: log2 of the per-port FIFO depth in bytes.
- clk  in  1  system clock; all logic on the rising edge.
- reset_n  in  1  reset, asynchronous assert, active-low.
- wr_en  in  1  host write strobe, one byte per cycle.
- wr_port  in  LOGNPORT  target port of the host write.
- wr_data  in  8  host byte.
- wr_accept  out  1  combinational: wr_en & ~full[wr_port].
- req  in  NPORT  per-port request for the next byte; level, held until granted.
- gnt_valid  out  1  one-cycle pulse: gnt_data belongs to gnt_port.
- gnt_port  out  LOGNPORT  port being served.
- gnt_data  out  8  byte popped for gnt_port.
- full  out  NPORT  per-port full flag, from registered pointers.
- empty  out  NPORT  per-port empty flag, from registered pointers.
- ram_we  out  1  equals wr_accept.
- ram_wa  out  LOGNPORT+LB2BUFSZ  {wr_port, watx[wr_port]}.
- ram_wd  out  8  equals wr_data.
- ram_ra  out  LOGNPORT+LB2BUFSZ  registered read address.
- ram_rd  in  8  registered RAM read data, one cycle after ram_ra.

## Operation
- Pointers: watx[i] and ratx[i] are LB2BUFSZ-bit counters that wrap modulo 2^LB2BUFSZ.
  - empty[i] = (watx[i] == ratx[i]).
  - full[i] = (watx[i]+1 == ratx[i]).
  - Usable depth is 2^LB2BUFSZ-1 bytes (31 at the default).
- Host write: on wr_accept, RAM is written and watx[wr_port] increments. A write to a full port is dropped: no pointer change, ram_we=0.
- Eligibility: elig = req & ~empty. In the cycle gnt_valid is high, the bit for gnt_port is also masked out, so a requester still holding req is not re-granted.
- FSM states:
  - IDLE: if elig≠0, pick the first set bit scanning upward (with wrap) from rr_last+1. Register sel and ram_ra={sel, ratx[sel]}, set rr_last=sel, go to ADDR. Otherwise stay in IDLE.
  - ADDR: the RAM samples ram_ra. Go to DATA.
  - DATA: ram_rd is valid. Register gnt_data=ram_rd, gnt_port=sel and gnt_valid=1, increment ratx[sel], go to IDLE.
- Requests for empty ports stay pending and are never granted until data arrives.
- Simultaneous write and pop on the same port: both pointers update in the same cycle. full and empty reflect both updates on the next cycle.
- Reset values:
  - Every watx and ratx is 0, so all empty=1 and full=0.
  - State is IDLE, rr_last=NPORT-1 (port 0 has first priority).
  - Outputs: gnt_valid=0, gnt_port=0, gnt_data=0, ram_ra=0.
- Reset asserted mid-grant aborts the grant immediately. No gnt_valid is produced and no pointer moves.

## Timing
- Request sampled at the end of IDLE cycle k. ADDR is cycle k+1, DATA is cycle k+2, and gnt_valid is high in cycle k+3.
- Peak throughput is one grant per 3 cycles: the gnt_valid cycle overlaps the next IDLE.
- A host write in cycle k makes the port eligible from cycle k+1.
- wr_accept, ram_we, ram_wa and ram_wd are combinational from wr_en, wr_port and the registered pointers. All other outputs are registered.

## Configuration
- SEROUT_FIFOARB_FLUSH_EN defined: adds input flush (NPORT bits).
  - flush[i] sets ratx[i] to the next-cycle value of watx[i], so it also discards a write accepted in the same cycle.
  - Flushing the port selected in ADDR or DATA cancels that grant: no gnt_valid, no pop. rr_last still advances.
- Macro undefined: no flush port and no flush logic.

## Structure
- Package serout_pkg holds:
  - The defaults for LB2BUFSZ and LOGNPORT.
  - The FSM state enum {IDLE, ADDR, DATA}.
  - A localparam for the pointer width.
- Sub-module rr_pick: a combinational round-robin picker with inputs elig and rr_last, and outputs any and sel.

## Test plan
- Reset, then write 0x55 to port 2 and hold req[2]:
  - Expect gnt_valid with gnt_port=2, gnt_data=0x55, exactly 3 cycles after req is sampled.
  - Then empty[2]=1.
- Write 32 bytes to port 0 with no req:
  - The first 31 are accepted; the 32nd gives wr_accept=0 and full[0]=1.
  - Draining returns bytes 0..30 in order.
- Fill ports 0, 3 and 7 with 2 bytes each and hold all req continuously:
  - Grant order is 0,3,7,0,3,7, with a gnt_valid every 3 cycles.
  - Then all empty.
- Hold req[4] with port 4 empty for 20 cycles:
  - No grant and ram_ra unchanged.
  - A write to port 4 gives a grant 4 cycles after the write cycle.
- Write to port 1 in the same cycle as its DATA-state pop with the FIFO holding 1 byte:
  - The next cycle shows empty[1]=0 and a pointer difference of 1.
- Assert reset_n=0 during ADDR:
  - Outputs immediately return to reset values.
  - No gnt_valid and all FIFOs empty.
  - With SEROUT_FIFOARB_FLUSH_EN: flush[2] during ADDR for port 2 gives no gnt_valid and empty[2]=1.
